// File: rtl/parity_pkg.sv
// Shared types and encodings for the serial parity engine.
package parity_pkg;

   typedef enum logic {
      ST_DATA = 1'b0,
      ST_PAR  = 1'b1
   } state_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;
   localparam logic MODE_GEN = 1'b0;
   localparam logic MODE_CHK = 1'b1;

endpackage

// File: rtl/frame_bit_counter.sv
// Counts accepted bits within a frame; clr has priority over inc.
module frame_bit_counter #(
   parameter  int unsigned FRAME_BITS = 3,
   localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt,
   output logic             last
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BITS - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc)
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt  = cnt_q;
   assign last = (cnt_q == LAST_IDX);

endmodule

// File: rtl/serial_parity_engine.sv
// Serial parity generator/checker for fixed-length frames of a 1-bit stream.
// Mode (odd/even, generate/check) is captured on the first bit of each frame.
module serial_parity_engine
   import parity_pkg::*;
#(
   parameter  int unsigned FRAME_BITS = 3,
   localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic w_valid,
   input  logic w,
   input  logic odd_sel,
   input  logic chk_en,
   output logic p,
   output logic p_valid,
   output logic err,
   output logic busy
);

   state_e           state_q, state_d;
   logic             acc_q, acc_d;
   logic             odd_l_q, odd_l_d;
   logic             chk_l_q, chk_l_d;
   logic             p_q, p_d;
   logic             p_valid_q, p_valid_d;
   logic             err_q, err_d;
   logic             busy_q, busy_d;

   logic             cnt_clr, cnt_inc, cnt_last;
   logic [CNT_W-1:0] cnt;

   frame_bit_counter #(
      .FRAME_BITS(FRAME_BITS)
   ) u_cnt (
      .clk  (clk),
      .reset(reset),
      .clr  (cnt_clr),
      .inc  (cnt_inc),
      .cnt  (cnt),
      .last (cnt_last)
   );

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      odd_l_d   = odd_l_q;
      chk_l_d   = chk_l_q;
      p_d       = p_q;
      p_valid_d = 1'b0;
      err_d     = err_q;
      busy_d    = busy_q;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;

      if (clr) begin
         state_d = ST_DATA;
         acc_d   = 1'b0;
         busy_d  = 1'b0;
         cnt_clr = 1'b1;
      end else if (w_valid) begin
         unique case (state_q)
            ST_DATA: begin
               if (cnt == '0) begin
                  odd_l_d = odd_sel;
                  chk_l_d = chk_en;
                  acc_d   = w;
                  busy_d  = 1'b1;
                  cnt_inc = 1'b1;
               end else if (!cnt_last) begin
                  acc_d   = acc_q ^ w;
                  cnt_inc = 1'b1;
               end else if (chk_l_q == MODE_CHK) begin
                  // counter runs on to FRAME_BITS while the parity bit is awaited
                  acc_d   = acc_q ^ w;
                  state_d = ST_PAR;
                  cnt_inc = 1'b1;
               end else begin
                  p_d       = acc_q ^ w ^ (odd_l_q == PAR_ODD);
                  p_valid_d = 1'b1;
                  err_d     = 1'b0;
                  busy_d    = 1'b0;
                  cnt_clr   = 1'b1;
               end
            end
            ST_PAR: begin
               p_d       = w;
               err_d     = (acc_q ^ (odd_l_q == PAR_ODD)) != w;
               p_valid_d = 1'b1;
               busy_d    = 1'b0;
               cnt_clr   = 1'b1;
               state_d   = ST_DATA;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_DATA;
         acc_q     <= 1'b0;
         odd_l_q   <= PAR_EVEN;
         chk_l_q   <= MODE_GEN;
         p_q       <= 1'b0;
         p_valid_q <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         odd_l_q   <= odd_l_d;
         chk_l_q   <= chk_l_d;
         p_q       <= p_d;
         p_valid_q <= p_valid_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
      end
   end

   assign p       = p_q;
   assign p_valid = p_valid_q;
   assign err     = err_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_serial_parity_engine.sv
// Bench for serial_parity_engine: a 3-bit and an 8-bit instance share a clock and reset.
module tb_serial_parity_engine;

   typedef struct {
      logic v, w, c, o, ch, eb, push, ep, ee;
   } vec_t;

   typedef struct {
      logic p;
      logic e;
      int   due;
   } exp_t;

   logic clk = 1'b0;
   logic reset, clr, w, odd_sel, chk_en, wv3, wv8;
   logic p3, pv3, err3, busy3;
   logic p8, pv8, err8, busy8;

   int   checks = 0;
   int   errors = 0;
   int   edge_cnt = 0;
   exp_t q3[$];
   exp_t q8[$];
   logic lp3, le3, lp8, le8;
   vec_t tbl[$];

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt++;

   serial_parity_engine #(.FRAME_BITS(3)) dut3 (
      .clk(clk), .reset(reset), .clr(clr), .w_valid(wv3), .w(w),
      .odd_sel(odd_sel), .chk_en(chk_en),
      .p(p3), .p_valid(pv3), .err(err3), .busy(busy3)
   );

   serial_parity_engine #(.FRAME_BITS(8)) dut8 (
      .clk(clk), .reset(reset), .clr(clr), .w_valid(wv8), .w(w),
      .odd_sel(odd_sel), .chk_en(chk_en),
      .p(p8), .p_valid(pv8), .err(err8), .busy(busy8)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // scoreboard: each pulse pops one expected result; between pulses p/err must hold
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         lp3 = 1'b0; le3 = 1'b0; lp8 = 1'b0; le8 = 1'b0;
      end else begin
         if (pv3) begin
            if (q3.size() == 0) begin
               checks++; errors++;
               $display("FAIL pv3_spurious actual=1 required=0");
            end else begin
               e = q3.pop_front();
               check("p3", p3, e.p);
               check("err3", err3, e.e);
               check("pv3_cycle", edge_cnt, e.due);
               lp3 = e.p; le3 = e.e;
            end
         end else begin
            check("p3_hold", p3, lp3);
            check("err3_hold", err3, le3);
         end
         if (pv8) begin
            if (q8.size() == 0) begin
               checks++; errors++;
               $display("FAIL pv8_spurious actual=1 required=0");
            end else begin
               e = q8.pop_front();
               check("p8", p8, e.p);
               check("err8", err8, e.e);
               check("pv8_cycle", edge_cnt, e.due);
               lp8 = e.p; le8 = e.e;
            end
         end else begin
            check("p8_hold", p8, lp8);
            check("err8_hold", err8, le8);
         end
      end
   end

   task automatic send(input logic s8, input logic v, input logic wb, input logic c,
                       input logic o, input logic ch, input logic eb,
                       input logic push, input logic ep, input logic ee);
      exp_t e;
      @(negedge clk);
      w = wb; clr = c; odd_sel = o; chk_en = ch;
      wv3 = v & ~s8;
      wv8 = v & s8;
      if (push) begin
         e.p = ep; e.e = ee; e.due = edge_cnt + 1;
         if (s8) q8.push_back(e);
         else    q3.push_back(e);
      end
      @(posedge clk);
      #1;
      if (s8) check("busy8", busy8, eb);
      else    check("busy3", busy3, eb);
   endtask

   // 8-bit frame MSB first with random gaps; mode inputs inverted after the first bit
   task automatic frame8(input logic [7:0] d, input logic o, input logic ch, input logic par);
      logic ref_par;
      ref_par = (^d) ^ o;
      for (int i = 7; i >= 0; i--) begin
         if (i < 7) begin
            repeat ($urandom_range(0, 3))
               send(1'b1, 1'b0, 1'($urandom), 1'b0, ~o, ~ch, 1'b1, 1'b0, 1'b0, 1'b0);
         end
         send(1'b1, 1'b1, d[i], 1'b0, (i == 7) ? o : ~o, (i == 7) ? ch : ~ch,
              (ch || i != 0), (!ch && i == 0), ref_par, 1'b0);
      end
      if (ch) begin
         repeat ($urandom_range(0, 3))
            send(1'b1, 1'b0, 1'($urandom), 1'b0, ~o, ~ch, 1'b1, 1'b0, 1'b0, 1'b0);
         send(1'b1, 1'b1, par, 1'b0, ~o, ~ch, 1'b0, 1'b1, par, ref_par != par);
      end
   endtask

   initial begin
      reset = 1'b0; clr = 1'b0; w = 1'b0; odd_sel = 1'b0; chk_en = 1'b0;
      wv3 = 1'b0; wv8 = 1'b0;

      //                v     w     clr   odd   chk   busy  push  p     err
      // generate even 1,0,1
      tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
      // check even 1,1,0 (gap) parity 1 -> mismatch
      tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1});
      // check even 1,1,0 parity 0 -> match
      tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
      // 1,1 then clr with w_valid, then generate even 1,0,0
      tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
      // generate odd latched, modes toggled mid-frame: 1,1,1
      tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
      // check odd latched, modes toggled mid-frame: 0,1,0 parity 1 -> mismatch
      tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1});
      // check even 1,0,1 aborted by clr while awaiting parity, then generate even 0,0,0
      tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
      // generate odd 0,0,0 back-to-back
      tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});

      #12;
      check("rst_p", p3, 0);
      check("rst_pv", pv3, 0);
      check("rst_err", err3, 0);
      check("rst_busy", busy3, 0);
      @(negedge clk);
      #1 reset = 1'b1;

      foreach (tbl[i])
         send(1'b0, tbl[i].v, tbl[i].w, tbl[i].c, tbl[i].o, tbl[i].ch,
              tbl[i].eb, tbl[i].push, tbl[i].ep, tbl[i].ee);

      // async reset mid-frame after a result with p=1, err=1
      send(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      send(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      send(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      send(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      send(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      send(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      wv3 = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("arst_p", p3, 0);
      check("arst_pv", pv3, 0);
      check("arst_err", err3, 0);
      check("arst_busy", busy3, 0);
      @(negedge clk);
      #1 reset = 1'b1;
      send(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      send(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      send(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      frame8(8'hB5, 1'b1, 1'b0, 1'b0);
      frame8(8'hB5, 1'b0, 1'b0, 1'b0);
      frame8(8'h3C, 1'b1, 1'b1, 1'b1);
      frame8(8'h01, 1'b0, 1'b1, 1'b0);

      send(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      check("q3_drained", q3.size(), 0);
      check("q8_drained", q8.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
